dmi_dtm_ctrl: RTL and testbench

DMI_DTM_CTRL -- requirements
Module: dmi_dtm_ctrl

---
 rtl/dmi_dtm_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dmi_dtm_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_dtm_ctrl.sv
// DTM-side DMI access controller: turns TAP dmi scans into debug-module requests.
// It tracks one outstanding transaction and maintains the sticky dmistat error.

package dm;
  localparam int unsigned DmiAddrW = 7;
  localparam int unsigned DmiDataW = 32;

  typedef logic [DmiAddrW-1:0] dmi_addr_t;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    dmi_addr_t             addr;
    dtm_op_e               op;
    logic [DmiDataW-1:0]   data;
  } dmi_req_t;

  typedef struct packed {
    logic [DmiDataW-1:0]   data;
    logic [1:0]            resp;
  } dmi_resp_t;
endpackage

module dmi_dtm_ctrl #(
  parameter int unsigned AbitsW = 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               update_i,
  input  logic               capture_i,
  input  logic [AbitsW+33:0] scan_i,
  output logic [AbitsW+33:0] capture_o,
  input  logic               dmireset_i,
  input  logic               dmihardreset_i,
  output logic [1:0]         dmistat_o,
  output logic               dmi_rst_no,
  output logic               dmi_req_valid_o,
  input  logic               dmi_req_ready_i,
  output dm::dmi_req_t       dmi_req_o,
  input  logic               dmi_resp_valid_i,
  output logic               dmi_resp_ready_o,
  input  dm::dmi_resp_t      dmi_resp_i
);

  localparam int unsigned ScanW = AbitsW + 34;
  localparam int unsigned DataW = 32;
  localparam int unsigned ErrW  = 2;

  localparam logic [ErrW-1:0] ErrNone   = 2'd0;
  localparam logic [ErrW-1:0] ErrFailed = 2'd2;
  localparam logic [ErrW-1:0] ErrBusy   = 2'd3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ       = 3'd1,
    WAIT_READ  = 3'd2,
    WRITE      = 3'd3,
    WAIT_WRITE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [AbitsW-1:0]  addr_q, addr_d;
  logic [DataW-1:0]   data_q, data_d;
  logic [ErrW-1:0]    error_q, error_d;
  logic               rst_q;

  logic [1:0]         scan_op;
  logic [DataW-1:0]   scan_data;
  logic [AbitsW-1:0]  scan_addr;
  logic               busy_c;
  logic               fail_c;

  assign scan_op   = scan_i[1:0];
  assign scan_data = scan_i[33:2];
  assign scan_addr = scan_i[ScanW-1:34];

  // Any TAP access to the dmi register while a transaction is in flight is a busy event
  assign busy_c = (update_i || capture_i) && (state_q != IDLE);

  // State and data registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      error_q <= ErrNone;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  // DMI reset: low during rst_ni and for the single cycle after a hard reset pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_q <= 1'b0;
    end else begin
      rst_q <= ~dmihardreset_i;
    end
  end

  // Next-state, address/data capture and sticky error tracking
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    error_d = error_q;
    fail_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (update_i && (error_q == ErrNone)) begin
          if (scan_op == dm::DTM_READ) begin
            addr_d  = scan_addr;
            state_d = READ;
          end else if (scan_op == dm::DTM_WRITE) begin
            addr_d  = scan_addr;
            data_d  = scan_data;
            state_d = WRITE;
          end
        end
      end
      READ: begin
        if (dmi_req_ready_i) state_d = WAIT_READ;
      end
      WRITE: begin
        if (dmi_req_ready_i) state_d = WAIT_WRITE;
      end
      WAIT_READ: begin
        if (dmi_resp_valid_i) begin
          data_d  = dmi_resp_i.data;
          fail_c  = (dmi_resp_i.resp != 2'd0);
          state_d = IDLE;
        end
      end
      WAIT_WRITE: begin
        if (dmi_resp_valid_i) begin
          fail_c  = (dmi_resp_i.resp != 2'd0);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (error_q == ErrNone) begin
      if (fail_c) begin
        error_d = ErrFailed;
      end else if (busy_c) begin
        error_d = ErrBusy;
      end
    end

    if (dmireset_i) error_d = ErrNone;

    // Hard reset abandons any in-flight handshake and wipes the register file
    if (dmihardreset_i) begin
      state_d = IDLE;
      addr_d  = '0;
      data_d  = '0;
      error_d = ErrNone;
    end
  end

  // Request and response handshake signals decode directly from the state register
  always_comb begin
    dmi_req_valid_o  = (state_q == READ) || (state_q == WRITE);
    dmi_resp_ready_o = (state_q == WAIT_READ) || (state_q == WAIT_WRITE);
    dmi_req_o.addr   = dm::dmi_addr_t'(addr_q);
    dmi_req_o.data   = data_q;
    case (state_q)
      READ:    dmi_req_o.op = dm::DTM_READ;
      WRITE:   dmi_req_o.op = dm::DTM_WRITE;
      default: dmi_req_o.op = dm::DTM_NOP;
    endcase
  end

  // A capture during a transaction must already show busy in the shifted-out word
  assign capture_o  = {addr_q, data_q, (capture_i && (state_q != IDLE)) ? ErrBusy : error_q};
  assign dmistat_o  = error_q;
  assign dmi_rst_no = rst_q;

endmodule

// File: tb/tb_dmi_dtm_ctrl.sv
// Scoreboard bench for dmi_dtm_ctrl: expected requests and captures are queued,
// and monitors compare them as the DUT presents accepted requests and captures.

module tb_dmi_dtm_ctrl;

  localparam int unsigned AbitsW = 7;
  localparam int unsigned ScanW  = AbitsW + 34;
  localparam int unsigned Budget = 50;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              update = 1'b0;
  logic              capture = 1'b0;
  logic [ScanW-1:0]  scan = '0;
  logic [ScanW-1:0]  capture_word;
  logic              dmireset = 1'b0;
  logic              dmihardreset = 1'b0;
  logic [1:0]        dmistat;
  logic              dmi_rst_n;
  logic              req_valid;
  logic              req_ready = 1'b0;
  dm::dmi_req_t      req;
  logic              resp_valid = 1'b0;
  logic              resp_ready;
  dm::dmi_resp_t     resp = '0;

  dm::dmi_req_t      req_q[$];
  logic [ScanW-1:0]  cap_q[$];
  int                n_vec = 0;
  int                n_err = 0;

  always #5 clk = ~clk;

  dmi_dtm_ctrl #(.AbitsW(AbitsW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .update_i         (update),
    .capture_i        (capture),
    .scan_i           (scan),
    .capture_o        (capture_word),
    .dmireset_i       (dmireset),
    .dmihardreset_i   (dmihardreset),
    .dmistat_o        (dmistat),
    .dmi_rst_no       (dmi_rst_n),
    .dmi_req_valid_o  (req_valid),
    .dmi_req_ready_i  (req_ready),
    .dmi_req_o        (req),
    .dmi_resp_valid_i (resp_valid),
    .dmi_resp_ready_o (resp_ready),
    .dmi_resp_i       (resp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Request monitor: every accepted request must match the head of the queue
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      if (req_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_req: got %h expected none", req);
      end else begin
        check("dmi_req", {23'h0, req}, {23'h0, req_q.pop_front()});
      end
    end
  end

  // Capture monitor: the word loaded on capture must match the queued expectation
  always @(negedge clk) begin
    if (rst_n && capture) begin
      if (cap_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_capture: got %h expected none", capture_word);
      end else begin
        check("capture_o", {23'h0, capture_word}, {23'h0, cap_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_req(input logic [AbitsW-1:0] a, input dm::dtm_op_e op, input logic [31:0] d);
    dm::dmi_req_t r;
    r.addr = a;
    r.op   = op;
    r.data = d;
    req_q.push_back(r);
  endtask

  task automatic do_update(input logic [1:0] op, input logic [AbitsW-1:0] a, input logic [31:0] d);
    scan   = {a, d, op};
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic do_capture(input logic [ScanW-1:0] exp);
    cap_q.push_back(exp);
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic wait_resp_ready();
    int n = 0;
    while (!resp_ready && n < Budget) begin
      tick();
      n++;
    end
    if (!resp_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_ready_timeout: got 0 after %0d cycles expected 1", n);
    end
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] r);
    wait_resp_ready();
    resp_valid = 1'b1;
    resp.data  = d;
    resp.resp  = r;
    tick();
    resp_valid = 1'b0;
    resp       = '0;
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_valid", 64'(req_valid), 64'd0);
    check("rst_resp_ready", 64'(resp_ready), 64'd0);
    check("rst_dmi_rst_n", 64'(dmi_rst_n), 64'd0);
    check("rst_dmistat", 64'(dmistat), 64'd0);
    check("rst_capture", {23'h0, capture_word}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_release_dmi_rst_n", 64'(dmi_rst_n), 64'd1);

    // Write then read back through the same address
    req_ready = 1'b1;
    exp_req(7'h04, dm::DTM_WRITE, 32'hDEADBEEF);
    do_update(2'd2, 7'h04, 32'hDEADBEEF);
    respond(32'h0, 2'd0);
    exp_req(7'h04, dm::DTM_READ, 32'hDEADBEEF);
    do_update(2'd1, 7'h04, 32'h12345678);
    respond(32'hDEADBEEF, 2'd0);
    do_capture({7'h04, 32'hDEADBEEF, 2'd0});
    exp_req(7'h10, dm::DTM_READ, 32'hDEADBEEF);
    do_update(2'd1, 7'h10, 32'h0);
    respond(32'hCAFEF00D, 2'd0);
    do_capture({7'h10, 32'hCAFEF00D, 2'd0});
    do_update(2'd3, 7'h11, 32'h1);
    check("op3_no_error", 64'(dmistat), 64'd0);

    // Backpressure: request held stable for five stalled cycles
    req_ready = 1'b0;
    exp_req(7'h21, dm::DTM_WRITE, 32'h0BADC0DE);
    do_update(2'd2, 7'h21, 32'h0BADC0DE);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(req_valid), 64'd1);
      check("stall_payload", {23'h0, req}, {23'h0, 7'h21, dm::DTM_WRITE, 32'h0BADC0DE});
      tick();
    end
    req_ready = 1'b1;
    respond(32'h0, 2'd0);
    check("after_write_valid", 64'(req_valid), 64'd0);

    // Busy: update during WaitRead is dropped and flagged
    exp_req(7'h08, dm::DTM_READ, 32'h0BADC0DE);
    do_update(2'd1, 7'h08, 32'h0);
    wait_resp_ready();
    do_update(2'd2, 7'h09, 32'h11111111);
    check("busy_dmistat", 64'(dmistat), 64'd3);
    do_capture({7'h08, 32'h0BADC0DE, 2'd3});
    respond(32'h55AA55AA, 2'd0);
    check("busy_sticky", 64'(dmistat), 64'd3);
    do_update(2'd1, 7'h0A, 32'h0);
    tick();
    tick();
    check("busy_update_ignored", 64'(req_valid), 64'd0);
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
    check("dmireset_clears", 64'(dmistat), 64'd0);
    exp_req(7'h0C, dm::DTM_READ, 32'h55AA55AA);
    do_update(2'd1, 7'h0C, 32'h0);
    respond(32'h00000077, 2'd0);
    do_capture({7'h0C, 32'h00000077, 2'd0});

    // Failed op: error response makes dmistat sticky at 2
    exp_req(7'h0D, dm::DTM_READ, 32'h00000077);
    do_update(2'd1, 7'h0D, 32'h0);
    respond(32'hFFFFFFFF, 2'd2);
    check("failed_dmistat", 64'(dmistat), 64'd2);
    do_update(2'd2, 7'h0E, 32'hAAAA0000);
    tick();
    tick();
    check("failed_update_ignored", 64'(req_valid), 64'd0);
    do_capture({7'h0D, 32'hFFFFFFFF, 2'd2});
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
    check("failed_cleared", 64'(dmistat), 64'd0);

    // dmireset wins over a simultaneous busy event, then hard reset in WaitWrite
    exp_req(7'h30, dm::DTM_WRITE, 32'h12345678);
    do_update(2'd2, 7'h30, 32'h12345678);
    wait_resp_ready();
    dmireset = 1'b1;
    do_capture({7'h30, 32'h12345678, 2'd3});
    dmireset = 1'b0;
    check("clear_wins", 64'(dmistat), 64'd0);
    scan         = {7'h31, 32'h0, 2'd1};
    update       = 1'b1;
    dmihardreset = 1'b1;
    tick();
    update       = 1'b0;
    dmihardreset = 1'b0;
    check("hard_dmi_rst_low", 64'(dmi_rst_n), 64'd0);
    check("hard_resp_ready", 64'(resp_ready), 64'd0);
    check("hard_valid", 64'(req_valid), 64'd0);
    check("hard_dmistat", 64'(dmistat), 64'd0);
    tick();
    check("hard_dmi_rst_high", 64'(dmi_rst_n), 64'd1);
    tick();
    check("hard_no_resp_ready", 64'(resp_ready), 64'd0);
    do_capture({7'h00, 32'h0, 2'd0});

    // Asynchronous reset while a read request is stalled
    req_ready = 1'b0;
    do_update(2'd1, 7'h05, 32'h0);
    check("pre_rst_valid", 64'(req_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(req_valid), 64'd0);
    check("async_resp_ready", 64'(resp_ready), 64'd0);
    check("async_dmi_rst_n", 64'(dmi_rst_n), 64'd0);
    check("async_dmistat", 64'(dmistat), 64'd0);
    check("async_capture", {23'h0, capture_word}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rerst_dmi_rst_n", 64'(dmi_rst_n), 64'd1);
    check("rerst_valid", 64'(req_valid), 64'd0);

    tick();
    check("req_queue_empty", 64'(req_q.size()), 64'd0);
    check("cap_queue_empty", 64'(cap_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
